// File: rtl/logic_operand_stage_pkg.sv
// logic_operand_stage_pkg: shared widths, logic opcodes and skid states
package logic_operand_stage_pkg;
  localparam int DEF_WORD_W = 24;
  localparam int DEF_RID_W = 4;
  localparam int DEF_OPC_W = 3;
  typedef enum logic [2:0] {
    OPC_AND = 3'd0,
    OPC_OR = 3'd1,
    OPC_XOR = 3'd2,
    OPC_CMB = 3'd3
  } logic_opc_e;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE = 2'd1,
    FULL = 2'd2
  } skid_state_e;
endpackage

// File: rtl/logic_operand_stage_if.sv
// logic_operand_stage_if: upstream, bypass and logic-unit handshake bundle
interface logic_operand_stage_if import logic_operand_stage_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int RID_W = DEF_RID_W,
  parameter int OPC_W = DEF_OPC_W
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [OPC_W-1:0] in_opc;
  logic [RID_W-1:0] in_ra_id;
  logic [RID_W-1:0] in_rb_id;
  logic [0:WORD_W-1] in_ra_data;
  logic [0:WORD_W-1] in_rb_data;
  logic [0:WORD_W-1] in_imm;
  logic in_sel_imm;
  logic in_cmp_b;
  logic byp_valid;
  logic [RID_W-1:0] byp_rid;
  logic [0:WORD_W-1] byp_data;
  logic out_valid;
  logic out_ready;
  logic [OPC_W-1:0] out_opc;
  logic [0:WORD_W-1] out_a;
  logic [0:WORD_W-1] out_b;
  modport master (
    output flush, in_valid, in_opc, in_ra_id, in_rb_id, in_ra_data, in_rb_data,
           in_imm, in_sel_imm, in_cmp_b, byp_valid, byp_rid, byp_data, out_ready,
    input  in_ready, out_valid, out_opc, out_a, out_b
  );
  modport slave (
    input  flush, in_valid, in_opc, in_ra_id, in_rb_id, in_ra_data, in_rb_data,
           in_imm, in_sel_imm, in_cmp_b, byp_valid, byp_rid, byp_data, out_ready,
    output in_ready, out_valid, out_opc, out_a, out_b
  );
endinterface

// File: rtl/logic_operand_stage_operand_resolve.sv
// operand_resolve: combinational A/B selection with bypass, r0 and complement
module operand_resolve import logic_operand_stage_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int RID_W = DEF_RID_W
) (
  input  logic [RID_W-1:0] ra_id,
  input  logic [RID_W-1:0] rb_id,
  input  logic [RID_W-1:0] byp_rid,
  input  logic [0:WORD_W-1] ra_data,
  input  logic [0:WORD_W-1] rb_data,
  input  logic [0:WORD_W-1] imm,
  input  logic [0:WORD_W-1] byp_data,
  input  logic sel_imm,
  input  logic cmp_b,
  input  logic byp_valid,
  output logic [0:WORD_W-1] a,
  output logic [0:WORD_W-1] b
);
  logic [0:WORD_W-1] b_reg;
  logic [0:WORD_W-1] b_raw;
  // register 0 reads as zero and is never bypassed
  always_comb begin
    a = ra_id == '0 ? '0 : (byp_valid && byp_rid == ra_id) ? byp_data : ra_data;
    b_reg = rb_id == '0 ? '0 : (byp_valid && byp_rid == rb_id) ? byp_data : rb_data;
    b_raw = sel_imm ? imm : b_reg;
    b = cmp_b ? ~b_raw : b_raw;
  end
endmodule

// File: rtl/logic_operand_stage.sv
// logic_operand_stage: operand resolve into a two-entry skid buffer toward the logic unit
module logic_operand_stage import logic_operand_stage_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W,
  parameter int RID_W = DEF_RID_W,
  parameter int OPC_W = DEF_OPC_W
) (
  input logic clk,
  input logic rst,
  logic_operand_stage_if.slave bus
);
  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [0:WORD_W-1] a;
    logic [0:WORD_W-1] b;
  } entry_t;
  skid_state_e state_q, state_d;
  entry_t out_q, skid_q, new_e;
  logic [0:WORD_W-1] res_a, res_b;
  logic in_ready_q, accept, consume, ld_new, ld_skid, ld_pop;
  operand_resolve #(.WORD_W(WORD_W), .RID_W(RID_W)) u_res (
    .ra_id(bus.in_ra_id),
    .rb_id(bus.in_rb_id),
    .byp_rid(bus.byp_rid),
    .ra_data(bus.in_ra_data),
    .rb_data(bus.in_rb_data),
    .imm(bus.in_imm),
    .byp_data(bus.byp_data),
    .sel_imm(bus.in_sel_imm),
    .cmp_b(bus.in_cmp_b),
    .byp_valid(bus.byp_valid),
    .a(res_a),
    .b(res_b)
  );
  assign new_e = {bus.in_opc, res_a, res_b};
  assign accept = bus.in_valid && in_ready_q;
  assign consume = state_q != EMPTY && bus.out_ready;
  // skid next state and register load selects; flush suppresses every load
  always_comb begin
    ld_new = !bus.flush && accept && (state_q == EMPTY || (state_q == ONE && consume));
    ld_skid = !bus.flush && accept && state_q == ONE && !consume;
    ld_pop = !bus.flush && consume && state_q == FULL;
    state_d = bus.flush ? EMPTY : ld_skid ? FULL : (ld_new || ld_pop) ? ONE : consume ? EMPTY : state_q;
  end
  // state, registered in_ready, OUT and SKID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= state_d != FULL;
      if (ld_new) out_q <= new_e;
      else if (ld_pop) out_q <= skid_q;
      if (ld_skid) skid_q <= new_e;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.out_opc = out_q.opc;
  assign bus.out_a = out_q.a;
  assign bus.out_b = out_q.b;
endmodule

// File: tb/tb_logic_operand_stage.sv
// tb_logic_operand_stage: directed self-checking bench for logic_operand_stage
module tb_logic_operand_stage;
  import logic_operand_stage_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic_operand_stage_if bus ();
  logic_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_opc = '0;
    bus.in_ra_id = '0;
    bus.in_rb_id = '0;
    bus.in_ra_data = '0;
    bus.in_rb_data = '0;
    bus.in_imm = '0;
    bus.in_sel_imm = 1'b0;
    bus.in_cmp_b = 1'b0;
    bus.byp_valid = 1'b0;
    bus.byp_rid = '0;
    bus.byp_data = '0;
  endtask
  task automatic set_in(input logic [2:0] opc, input logic [3:0] ra, input logic [23:0] rad,
                        input logic [3:0] rb, input logic [23:0] rbd);
    bus.in_valid = 1'b1;
    bus.in_opc = opc;
    bus.in_ra_id = ra;
    bus.in_ra_data = rad;
    bus.in_rb_id = rb;
    bus.in_rb_data = rbd;
    bus.in_sel_imm = 1'b0;
    bus.in_cmp_b = 1'b0;
  endtask
  task automatic test_reset;
    idle();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b exp 0", bus.out_valid); end
    rst = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_a !== 24'h000000) begin errors++; $display("FAIL reset_a: got %h exp 000000", bus.out_a); end
    checks++; if (bus.out_b !== 24'h000000) begin errors++; $display("FAIL reset_b: got %h exp 000000", bus.out_b); end
    checks++; if (bus.out_opc !== 3'd0) begin errors++; $display("FAIL reset_opc: got %0d exp 0", bus.out_opc); end
  endtask
  task automatic test_plain;
    bus.out_ready = 1'b1;
    set_in(OPC_OR, 4'd2, 24'hF010FF, 4'd3, 24'hFFF000);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL plain_valid: got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_a !== 24'hF010FF) begin errors++; $display("FAIL plain_a: got %h exp F010FF", bus.out_a); end
    checks++; if (bus.out_b !== 24'hFFF000) begin errors++; $display("FAIL plain_b: got %h exp FFF000", bus.out_b); end
    checks++; if (bus.out_opc !== 3'd1) begin errors++; $display("FAIL plain_opc: got %0d exp 1", bus.out_opc); end
    idle();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL plain_drain: got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_bypass;
    bus.out_ready = 1'b1;
    bus.byp_valid = 1'b1;
    bus.byp_rid = 4'd2;
    bus.byp_data = 24'h123456;
    set_in(OPC_XOR, 4'd2, 24'h111111, 4'd3, 24'h0ABCDE);
    tick();
    checks++; if (bus.out_a !== 24'h123456) begin errors++; $display("FAIL byp_a: got %h exp 123456", bus.out_a); end
    checks++; if (bus.out_b !== 24'h0ABCDE) begin errors++; $display("FAIL byp_b_miss: got %h exp 0ABCDE", bus.out_b); end
    checks++; if (bus.out_opc !== 3'd2) begin errors++; $display("FAIL byp_opc: got %0d exp 2", bus.out_opc); end
    set_in(OPC_AND, 4'd0, 24'h777777, 4'd2, 24'h222222);
    tick();
    checks++; if (bus.out_a !== 24'h000000) begin errors++; $display("FAIL byp_r0_a: got %h exp 000000", bus.out_a); end
    checks++; if (bus.out_b !== 24'h123456) begin errors++; $display("FAIL byp_b_hit: got %h exp 123456", bus.out_b); end
    bus.byp_rid = 4'd0;
    set_in(OPC_OR, 4'd0, 24'h999999, 4'd0, 24'h888888);
    tick();
    checks++; if (bus.out_a !== 24'h000000) begin errors++; $display("FAIL byp_r0_rid0_a: got %h exp 000000", bus.out_a); end
    checks++; if (bus.out_b !== 24'h000000) begin errors++; $display("FAIL byp_r0_rid0_b: got %h exp 000000", bus.out_b); end
    bus.byp_valid = 1'b0;
    bus.byp_rid = 4'd2;
    set_in(OPC_OR, 4'd2, 24'h333333, 4'd2, 24'h222222);
    tick();
    checks++; if (bus.out_a !== 24'h333333) begin errors++; $display("FAIL byp_off_a: got %h exp 333333", bus.out_a); end
    checks++; if (bus.out_b !== 24'h222222) begin errors++; $display("FAIL byp_off_b: got %h exp 222222", bus.out_b); end
    idle();
    tick();
  endtask
  task automatic test_imm;
    bus.out_ready = 1'b1;
    set_in(OPC_CMB, 4'd1, 24'hA5A5A5, 4'd3, 24'hFFF000);
    bus.in_sel_imm = 1'b1;
    bus.in_imm = 24'h0000FF;
    bus.in_cmp_b = 1'b1;
    tick();
    checks++; if (bus.out_b !== 24'hFFFF00) begin errors++; $display("FAIL imm_cmp_b: got %h exp FFFF00", bus.out_b); end
    checks++; if (bus.out_a !== 24'hA5A5A5) begin errors++; $display("FAIL imm_a: got %h exp A5A5A5", bus.out_a); end
    checks++; if (bus.out_opc !== 3'd3) begin errors++; $display("FAIL imm_opc: got %0d exp 3", bus.out_opc); end
    bus.in_sel_imm = 1'b0;
    tick();
    checks++; if (bus.out_b !== 24'h000FFF) begin errors++; $display("FAIL reg_cmp_b: got %h exp 000FFF", bus.out_b); end
    bus.in_sel_imm = 1'b1;
    bus.in_cmp_b = 1'b0;
    bus.in_imm = 24'hABCDEF;
    bus.byp_valid = 1'b1;
    bus.byp_rid = 4'd3;
    bus.byp_data = 24'h555555;
    tick();
    checks++; if (bus.out_b !== 24'hABCDEF) begin errors++; $display("FAIL imm_over_byp_b: got %h exp ABCDEF", bus.out_b); end
    idle();
    tick();
  endtask
  task automatic test_skid;
    bus.out_ready = 1'b0;
    set_in(OPC_AND, 4'd1, 24'h000001, 4'd1, 24'h000000);
    tick();
    checks++; if (bus.out_a !== 24'h000001) begin errors++; $display("FAIL skid_first: got %h exp 000001", bus.out_a); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_one: got %b exp 1", bus.in_ready); end
    bus.in_ra_data = 24'h000002;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full: got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_a !== 24'h000001) begin errors++; $display("FAIL skid_hold1: got %h exp 000001", bus.out_a); end
    bus.in_ra_data = 24'h000003;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_stall: got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_a !== 24'h000001) begin errors++; $display("FAIL skid_hold2: got %h exp 000001", bus.out_a); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_a !== 24'h000002) begin errors++; $display("FAIL skid_second: got %h exp 000002", bus.out_a); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b exp 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_a !== 24'h000003) begin errors++; $display("FAIL skid_third: got %h exp 000003", bus.out_a); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL skid_third_valid: got %b exp 1", bus.out_valid); end
    idle();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain: got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_flush;
    bus.out_ready = 1'b0;
    set_in(OPC_XOR, 4'd1, 24'h00000A, 4'd1, 24'h000000);
    tick();
    bus.in_ra_data = 24'h00000B;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: got %b exp 0", bus.in_ready); end
    bus.flush = 1'b1;
    bus.in_ra_data = 24'h00000C;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", bus.in_ready); end
    idle();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: got %b exp 0", bus.out_valid); end
    bus.out_ready = 1'b1;
    set_in(OPC_XOR, 4'd1, 24'h00000D, 4'd1, 24'h000000);
    tick();
    checks++; if (bus.out_a !== 24'h00000D) begin errors++; $display("FAIL flush_next: got %h exp 00000D", bus.out_a); end
    idle();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b exp 0", bus.out_valid); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_plain();
    test_bypass();
    test_imm();
    test_skid();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
